hyperbus_burst_splitter: RTL

Command-path stage between the AXI front end and the HyperBus PHY FSM. It accepts one AXI-style burst command (INCR or WRAP, any size up to 2^MaxSizeLog bytes, unaligned start allowed). It emits a sequence of linear PHY transfers in 16-bit-word units. Each transfer is bounded by a row boundary, a chip boundary and a maximum word count. It generalises the fixed 4 KiB / two-chip splitting with WRAP support, parametric chip count and out-of-range detection.

---
 rtl/hyperbus_burst_splitter_if.sv | 64 ++++++
 rtl/hyperbus_burst_splitter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hyperbus_burst_splitter_if.sv
// ---------------------------------------------------------------------------
// hyperbus_burst_splitter_if
//   Bundles the command handshake (AXI-style burst descriptor in) and the
//   linear PHY transfer handshake (out) of the HyperBus burst splitter.
//   Signal suffixes (_i/_o) are named from the splitter's point of view.
//
//   slave  modport : the splitter itself
//   master modport : whatever drives commands and consumes transfers
//
//   Command side : in_valid_i/in_ready_o, in_addr_i, in_len_i, in_size_i,
//                  in_wrap_i, in_write_i
//   Transfer side: out_valid_o/out_ready_i, out_word_addr_o, out_words_o,
//                  out_cs_o, out_write_o, out_lead_byte_o, out_trail_byte_o,
//                  out_first_o, out_last_o
//   Status       : err_o (one-cycle error pulse)
// ---------------------------------------------------------------------------
interface hyperbus_burst_splitter_if #(
    parameter int AddrWidth     = 32,
    parameter int LenWidth      = 8,
    parameter int NumChips      = 2,
    parameter int ChipAddrWidth = 23,
    parameter int MaxWords      = 256
);
    localparam int WordsWidth = $clog2(MaxWords + 1);

    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [AddrWidth-1:0]     in_addr_i;
    logic [LenWidth-1:0]      in_len_i;
    logic [2:0]               in_size_i;
    logic                     in_wrap_i;
    logic                     in_write_i;

    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [ChipAddrWidth-2:0] out_word_addr_o;
    logic [WordsWidth-1:0]    out_words_o;
    logic [NumChips-1:0]      out_cs_o;
    logic                     out_write_o;
    logic                     out_lead_byte_o;
    logic                     out_trail_byte_o;
    logic                     out_first_o;
    logic                     out_last_o;

    logic                     err_o;

    modport slave (
        input  in_valid_i, in_addr_i, in_len_i, in_size_i, in_wrap_i, in_write_i,
        output in_ready_o,
        output out_valid_o, out_word_addr_o, out_words_o, out_cs_o, out_write_o,
        output out_lead_byte_o, out_trail_byte_o, out_first_o, out_last_o,
        input  out_ready_i,
        output err_o
    );

    modport master (
        output in_valid_i, in_addr_i, in_len_i, in_size_i, in_wrap_i, in_write_i,
        input  in_ready_o,
        input  out_valid_o, out_word_addr_o, out_words_o, out_cs_o, out_write_o,
        input  out_lead_byte_o, out_trail_byte_o, out_first_o, out_last_o,
        output out_ready_i,
        input  err_o
    );
endinterface

// File: rtl/hyperbus_burst_splitter.sv
// ---------------------------------------------------------------------------
// hyperbus_burst_splitter
//   Takes one AXI-style burst command (INCR or WRAP, unaligned start allowed)
//   and emits a series of linear HyperBus transfers in 16-bit word units.
//   Each transfer stays inside one 2^BoundaryLog-byte row, inside one chip
//   and at most MaxWords words long. Commands that start beyond the last
//   chip, or use an illegal beat size, raise err_o without any transfer;
//   commands that run off the top of the last chip are clipped and raise
//   err_o on their final transfer.
//
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   bus    : hyperbus_burst_splitter_if.slave (command in, transfers out,
//            err_o pulse)
// ---------------------------------------------------------------------------
module hyperbus_burst_splitter #(
    parameter int AddrWidth     = 32,
    parameter int LenWidth      = 8,
    parameter int MaxSizeLog    = 4,
    parameter int NumChips      = 2,
    parameter int ChipAddrWidth = 23,
    parameter int BoundaryLog   = 11,
    parameter int MaxWords      = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    hyperbus_burst_splitter_if.slave bus
);
    // Two spare bits so start + total length can never wrap around.
    localparam int W         = AddrWidth + 2;
    localparam int WordsW    = $clog2(MaxWords + 1);
    localparam int ChipIdxW  = W - ChipAddrWidth;

    typedef logic [W-1:0] addr_t;

    localparam addr_t TopAddr       = addr_t'(NumChips) << ChipAddrWidth;
    localparam addr_t BoundBytes    = addr_t'(1) << BoundaryLog;
    localparam addr_t ChipBytes     = addr_t'(1) << ChipAddrWidth;
    localparam addr_t MaxPieceBytes = addr_t'(2 * MaxWords);

    typedef enum logic {IDLE, SPLIT} state_t;

    function automatic addr_t min_bytes(input addr_t a, input addr_t b);
        return (a < b) ? a : b;
    endfunction

    state_t state_p0, state_next;
    logic   err_start_p0;

    // Per-command working registers (data path, loaded on acceptance).
    addr_t  cur_p0;
    addr_t  rem_p0;
    logic   pend_p0;
    addr_t  seg2_addr_p0;
    addr_t  seg2_rem_p0;
    logic   first_p0;
    logic   write_p0;

    logic   accept, take, vld_p0;

    // Command decode.
    addr_t  a_ext, beat_mask, total, wrap_base, seg1_bytes, seg2_bytes;
    logic   wrap_len_ok, wrap_ok, cmd_bad;

    always_comb begin
        a_ext       = addr_t'(bus.in_addr_i);
        beat_mask   = (addr_t'(1) << bus.in_size_i) - addr_t'(1);
        total       = (addr_t'(bus.in_len_i) + addr_t'(1)) << bus.in_size_i;
        wrap_len_ok = (bus.in_len_i == LenWidth'(1)) || (bus.in_len_i == LenWidth'(3)) ||
                      (bus.in_len_i == LenWidth'(7)) || (bus.in_len_i == LenWidth'(15));
        wrap_ok     = bus.in_wrap_i && wrap_len_ok;
        // Wrap lengths are powers of two, so aligning down is a simple mask.
        wrap_base   = a_ext & ~(total - addr_t'(1));
        seg1_bytes  = wrap_ok ? (wrap_base + total - a_ext) : (total - (a_ext & beat_mask));
        seg2_bytes  = a_ext - wrap_base;
        cmd_bad     = (bus.in_size_i > 3'(MaxSizeLog)) || (a_ext >= TopAddr);
    end

    // Piece generation from the current position.
    addr_t                  to_bound, to_chip, to_max, n, piece_end;
    logic                   seg_done, cmd_done, trunc, piece_last;
    logic [ChipIdxW-1:0]    chip_idx;
    logic [NumChips-1:0]    cs;
    logic [WordsW-1:0]      words;

    always_comb begin
        to_bound   = BoundBytes - (cur_p0 & (BoundBytes - addr_t'(1)));
        to_chip    = ChipBytes - (cur_p0 & (ChipBytes - addr_t'(1)));
        // An odd start wastes the lower byte of the first word.
        to_max     = MaxPieceBytes - addr_t'(cur_p0[0]);
        n          = min_bytes(min_bytes(rem_p0, to_bound), min_bytes(to_chip, to_max));
        piece_end  = cur_p0 + n;
        seg_done   = (n == rem_p0);
        cmd_done   = seg_done && !pend_p0;
        // Reaching the top of the last chip with bytes still owed means clipping.
        trunc      = (piece_end == TopAddr) && !cmd_done;
        piece_last = cmd_done || trunc;
        // The difference is below 2^WordsW, so modular truncation is exact.
        words      = WordsW'((piece_end + addr_t'(1)) >> 1) - WordsW'(cur_p0 >> 1);
        chip_idx   = cur_p0[W-1:ChipAddrWidth];
        cs         = '0;
        for (int i = 0; i < NumChips; i++) begin
            cs[i] = (chip_idx == ChipIdxW'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_p0     <= IDLE;
            err_start_p0 <= 1'b0;
        end else begin
            state_p0     <= state_next;
            err_start_p0 <= accept && cmd_bad;
        end
    end

    always_comb begin
        state_next = state_p0;
        accept     = 1'b0;
        take       = 1'b0;
        vld_p0     = 1'b0;
        bus.in_ready_o = 1'b0;
        case (state_p0)
            IDLE: begin
                bus.in_ready_o = rst_ni;
                accept         = bus.in_valid_i && rst_ni;
                if (accept && !cmd_bad) begin
                    state_next = SPLIT;
                end
            end
            SPLIT: begin
                vld_p0 = 1'b1;
                take   = bus.out_ready_i;
                if (take && piece_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            cur_p0       <= a_ext;
            rem_p0       <= seg1_bytes;
            pend_p0      <= wrap_ok && (seg2_bytes != '0);
            seg2_addr_p0 <= wrap_base;
            seg2_rem_p0  <= seg2_bytes;
            first_p0     <= 1'b1;
            write_p0     <= bus.in_write_i;
        end else if (take) begin
            first_p0 <= 1'b0;
            if (seg_done) begin
                // Jump back to the wrap base for the second segment.
                cur_p0  <= seg2_addr_p0;
                rem_p0  <= seg2_rem_p0;
                pend_p0 <= 1'b0;
            end else begin
                cur_p0 <= piece_end;
                rem_p0 <= rem_p0 - n;
            end
        end
    end

    // Fields read zero whenever no transfer is offered.
    assign bus.out_valid_o      = vld_p0;
    assign bus.out_word_addr_o  = vld_p0 ? cur_p0[ChipAddrWidth-1:1] : '0;
    assign bus.out_words_o      = vld_p0 ? words : '0;
    assign bus.out_cs_o         = vld_p0 ? cs : '0;
    assign bus.out_write_o      = vld_p0 && write_p0;
    assign bus.out_lead_byte_o  = vld_p0 && cur_p0[0];
    assign bus.out_trail_byte_o = vld_p0 && piece_end[0];
    assign bus.out_first_o      = vld_p0 && first_p0;
    assign bus.out_last_o       = vld_p0 && piece_last;
    assign bus.err_o            = err_start_p0 || (take && trunc);

endmodule
